// File: rtl/store_pkg.sv
// Shared definitions for the store alignment path: funct3 encodings, size/strobe helpers
// and the store-buffer entry layout (sized for the widest supported XLEN/address).
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    // Fields are 64-bit wide; narrower configurations use the low bits only.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } store_entry_t;

    function automatic logic [3:0] size_from_funct3(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3)
            F3_SB:   size = 4'd1;
            F3_SH:   size = 4'd2;
            F3_SW:   size = 4'd4;
            F3_SD:   size = 4'd8;
            default: size = 4'd1;
        endcase
        return size;
    endfunction

    function automatic logic [7:0] strb_mask(input logic [3:0] size, input logic [2:0] off);
        logic [8:0] ones;
        ones = (9'd1 << size) - 9'd1;
        return ones[7:0] << off;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Generic synchronous FIFO with occupancy count; push and pop may occur in the same cycle.
module sb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/store_align_buffer.sv
// Store path: aligns SB/SH/SW/SD requests into lane-shifted writes with strobes and queues
// them for memory. Optional macro STORE_MISALIGN_TRAP_EN drops misaligned stores and flags them.
module store_align_buffer
    import store_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [XLEN-1:0]          st_data,
    input  logic [2:0]               st_funct3,
    output logic                     st_misalign,
    output logic                     st_illegal,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_wstrb,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    logic [2:0]   off3, eff_off, size_m1;
    logic [3:0]   size;
    logic         illegal, misalign_raw, drop;
    logic [7:0]   byte_en, strb8;
    logic [63:0]  st64, masked64, shifted64;
    logic         accept, push, pop, full, empty;
    store_entry_t entry, head;
    logic         illegal_q;

    always_comb begin
        off3         = 3'(st_addr[OW-1:0]);
        illegal      = !((st_funct3 inside {F3_SB, F3_SH, F3_SW}) ||
                         (XLEN == 64 && st_funct3 == F3_SD));
        size         = size_from_funct3(st_funct3);
        size_m1      = 3'(size - 4'd1);
        misalign_raw = (off3 & size_m1) != 3'd0;
`ifdef STORE_MISALIGN_TRAP_EN
        eff_off      = off3;
        drop         = illegal || misalign_raw;
`else
        // Low address bits below the access size are ignored.
        eff_off      = off3 & ~size_m1;
        drop         = illegal;
`endif
        byte_en  = strb_mask(size, 3'd0);
        st64     = 64'(st_data);
        masked64 = '0;
        for (int i = 0; i < 8; i++) begin
            masked64[8*i +: 8] = byte_en[i] ? st64[8*i +: 8] : 8'h00;
        end
        shifted64   = masked64 << {eff_off, 3'b000};
        strb8       = strb_mask(size, eff_off);
        entry.addr  = 64'({st_addr[ADDR_W-1:OW], {OW{1'b0}}});
        entry.wdata = shifted64;
        entry.wstrb = strb8;
    end

    assign accept = st_valid && st_ready;
    assign push   = accept && !drop;
    assign pop    = mem_valid && mem_ready;

    sb_fifo #(
        .WIDTH ($bits(store_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (sb_count),
        .full      (full),
        .empty     (empty)
    );

    assign st_ready  = !full;
    assign sb_empty  = empty;
    assign mem_valid = !empty;
    assign mem_addr  = head.addr[ADDR_W-1:0];
    assign mem_wdata = head.wdata[XLEN-1:0];
    assign mem_wstrb = head.wstrb[NB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && illegal;
        end
    end
    assign st_illegal = illegal_q;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && !illegal && misalign_raw;
        end
    end
    assign st_misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_raw;
    assign st_misalign     = 1'b0;
`endif

    // Upper bits of the wide entry/intermediates are unused in narrower configurations.
    logic unused_bits;
    assign unused_bits = ^{head, shifted64, strb8};

endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboard bench for store_align_buffer: directed test-plan sequences plus random traffic.
module tb_store_align_buffer;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NB     = XLEN / 8;

    logic                   clk, rst_n;
    logic                   st_valid, st_ready;
    logic [ADDR_W-1:0]      st_addr;
    logic [XLEN-1:0]        st_data;
    logic [2:0]             st_funct3;
    logic                   st_misalign, st_illegal;
    logic                   mem_valid, mem_ready;
    logic [ADDR_W-1:0]      mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [NB-1:0]          mem_wstrb;
    logic [$clog2(DEPTH):0] sb_count;
    logic                   sb_empty;

    store_align_buffer #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_funct3   (st_funct3),
        .st_misalign (st_misalign),
        .st_illegal  (st_illegal),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .sb_count    (sb_count),
        .sb_empty    (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic [NB-1:0]     strb;
    } mem_exp_t;

    typedef struct {
        bit ill;
        bit mis;
        int cnt;
    } cyc_exp_t;

    mem_exp_t exp_mem[$];
    cyc_exp_t exp_cyc[$];
    int       model_cnt;
    int       checks;
    int       passed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // One bus cycle: drive inputs after the edge, then predict the effect of the next edge.
    task automatic cycle(input bit v, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d,
                         input logic [2:0] f3, input bit mr);
        bit          acc, pop, ill, mis, push;
        int          size, off, offe;
        logic [63:0] msk, d64;
        mem_exp_t    e;
        @(posedge clk);
        #1;
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f3;
        mem_ready = mr;
        @(negedge clk);
        #1;
        acc  = v && (model_cnt != DEPTH);
        pop  = mr && (model_cnt != 0);
        ill  = 0;
        mis  = 0;
        push = 0;
        size = 1;
        if (f3 == 3'd0) size = 1;
        else if (f3 == 3'd1) size = 2;
        else if (f3 == 3'd2) size = 4;
        else if (f3 == 3'd3 && XLEN == 64) size = 8;
        else ill = 1;
        if (acc && !ill) begin
            off = int'(a % NB);
`ifdef STORE_MISALIGN_TRAP_EN
            if (off % size != 0) mis = 1;
            offe = off;
`else
            offe = off - (off % size);
`endif
            if (!mis) begin
                push   = 1;
                msk    = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
                d64    = (64'(d) & msk) << (8 * offe);
                e.addr = a - ADDR_W'(off);
                e.data = d64[XLEN-1:0];
                e.strb = NB'(((1 << size) - 1) << offe);
                exp_mem.push_back(e);
            end
        end
        model_cnt = model_cnt + int'(push) - int'(pop);
        exp_cyc.push_back('{ill: acc && ill, mis: mis, cnt: model_cnt});
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 3'd0, mr);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        #1;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_sb_count", sb_count, 0);
        check("rst_st_ready", st_ready, 1);
        check("rst_sb_empty", sb_empty, 1);
        exp_mem.delete();
        exp_cyc.delete();
        model_cnt = 0;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle status checks and in-order head comparison on each dequeue.
    always @(negedge clk) begin
        cyc_exp_t c;
        mem_exp_t m;
        if (rst_n) begin
            if (exp_cyc.size() > 0) begin
                c = exp_cyc.pop_front();
                check("sb_count", sb_count, c.cnt);
                check("sb_empty", sb_empty, c.cnt == 0);
                check("st_ready", st_ready, c.cnt != DEPTH);
                check("mem_valid", mem_valid, c.cnt != 0);
                check("st_illegal", st_illegal, c.ill);
                check("st_misalign", st_misalign, c.mis);
            end
            if (mem_valid && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected_dequeue", 1, 0);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_wdata", mem_wdata, m.data);
                    check("mem_wstrb", mem_wstrb, m.strb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3;
        checks    = 0;
        passed    = 0;
        model_cnt = 0;
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_funct3 = 3'd0;
        mem_ready = 1'b0;
        #2;
        check("reset_st_ready", st_ready, 1);
        check("reset_mem_valid", mem_valid, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_mem_wstrb", mem_wstrb, 0);
        check("reset_sb_count", sb_count, 0);
        check("reset_sb_empty", sb_empty, 1);
        check("reset_st_misalign", st_misalign, 0);
        check("reset_st_illegal", st_illegal, 0);
        #10;
        rst_n = 1'b1;

        // Test-plan directed stores
        cycle(1, 32'h1003, 32'hAABBCCDD, 3'b000, 1);
        cycle(1, 32'h2002, 32'h00001234, 3'b001, 1);
        cycle(1, 32'h2001, 32'h55667788, 3'b010, 1);
        cycle(1, 32'h3000, 32'h11111111, 3'b011, 1);
        cycle(1, 32'h3004, 32'h22222222, 3'b111, 1);
        idle(3, 1);

        // Fill with memory stalled, fifth store must be refused, then drain in order
        for (int i = 0; i < 5; i++) cycle(1, 32'h4000 + 32'(4 * i), $urandom, 3'b010, 0);
        idle(2, 0);
        idle(6, 1);

        // Half full, then simultaneous enqueue/dequeue across pointer wrap
        cycle(1, 32'h5000, $urandom, 3'b010, 0);
        cycle(1, 32'h5005, $urandom, 3'b000, 0);
        for (int i = 0; i < 10; i++) cycle(1, 32'h5100 + 32'(2 * i), $urandom, 3'b001, 1);
        idle(4, 1);

        // Reset with three queued entries
        for (int i = 0; i < 3; i++) cycle(1, 32'h6000 + 32'(4 * i), $urandom, 3'b010, 0);
        mid_reset();
        idle(2, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, f3,
                  $urandom_range(0, 3) != 0);
        end
        idle(DEPTH + 3, 1);
        @(negedge clk);
        #2;
        check("drain_empty", exp_mem.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Parametrised store path between the execute stage and data memory. It accepts RISC-V store requests (SB/SH/SW, and SD when XLEN=64) over a valid/ready handshake and converts each one into a lane-aligned write with byte strobes. Converted writes are queued in a DEPTH-entry FIFO store buffer and drained to the memory port over a second valid/ready handshake. Stores with a misaligned address or an unsupported funct3 are flagged and not queued.

## Interface
Parameters:
- XLEN, 32: data width; legal values are 32 and 64.
- ADDR_W, 32: byte-address width.
- DEPTH, 4: store-buffer entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- st_valid  in  1  store request valid.
- st_ready  out  1  unit can accept a request.
- st_addr  in  ADDR_W  byte address.
- st_data  in  XLEN  register value; only the low bits of the access size are used.
- st_funct3  in  3  store size: 000 SB, 001 SH, 010 SW, 011 SD.
- st_misalign  out  1  one-cycle pulse: an accepted store was misaligned.
- st_illegal  out  1  one-cycle pulse: an accepted store had an unsupported funct3.
- mem_valid  out  1  buffer head valid.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  ADDR_W  XLEN-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  lane-shifted write data; unused lanes are 0.
- mem_wstrb  out  XLEN/8  byte strobes.
- sb_count  out  log2(DEPTH)+1  number of entries currently in the buffer.
- sb_empty  out  1  buffer empty (sb_count==0); used by fence logic.

## Operation
- Accept condition: st_valid && st_ready.
- st_ready = (sb_count != DEPTH). There is no pass-through when the buffer is full.
- Terms: OFF = st_addr[log2(XLEN/8)-1:0]; SIZE = 1, 2, 4 or 8 bytes, taken from funct3.
- Strobe: low SIZE bits set, shifted left by OFF.
- Data: st_data masked to SIZE bytes, shifted left by 8*OFF. No sign extension.
- Illegal funct3: any value other than 000–010, plus 011 when XLEN=32.
- Misaligned: OFF is not a multiple of SIZE (behaviour depends on the macro, see Configuration).
- A legal, aligned accepted store is written at the tail; the tail pointer increments.
- An illegal or misaligned store completes the handshake but is not enqueued. Its error pulse is raised instead.
- Dequeue condition: mem_valid && mem_ready. The head pointer increments.
- mem_valid = !sb_empty. mem_addr, mem_wdata and mem_wstrb are driven from the head entry registers.
- Entries drain in strict program order.
- Enqueue and dequeue in the same cycle: sb_count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The extra count bit distinguishes full from empty.

## Timing
- Reset (async assert, sync deassert externally): st_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, sb_count=0, sb_empty=1, st_misalign=0, st_illegal=0. All entries are invalidated.
- Reset asserted mid-operation: all queued stores are discarded immediately.
- Enqueue-to-memory latency: a store accepted in cycle N appears on mem_* in cycle N+1 if the buffer was empty.
- Error pulses are registered and are high during cycle N+1 for an acceptance in cycle N.
- st_misalign and st_illegal are never both high. Illegal takes priority.
- st_ready falls in the cycle after the enqueue that fills the buffer.
- st_ready rises in the cycle after the first dequeue from a full buffer.
- mem_* outputs stay stable while mem_valid && !mem_ready.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - Misaligned stores pulse st_misalign and are dropped, so a precise trap can be taken upstream.
- STORE_MISALIGN_TRAP_EN undefined:
  - st_misalign is tied to 0.
  - OFF is rounded down to a multiple of SIZE (low address bits ignored) and the store is enqueued normally.

## Structure
- Shared package store_pkg holds:
  - funct3 constants F3_SB, F3_SH, F3_SW, F3_SD;
  - a size-from-funct3 function;
  - a strobe-mask function;
  - the store-entry struct typedef {addr, wdata, wstrb}.
- Sub-module sb_fifo: a generic synchronous FIFO with parametrised width/depth, a count output, and simultaneous push/pop.
- The top level contains the alignment/strobe logic and the error registers.

## Test plan
- SB, XLEN=32, addr 0x1003, data 0xAABBCCDD, mem_ready=1 → next cycle: mem_addr 0x1000, mem_wdata 0xDD000000, mem_wstrb 1000.
- SH, addr 0x2002, data 0x1234 → mem_wdata 0x12340000, wstrb 1100. Then SW at 0x2001:
  - with the macro: st_misalign pulses and sb_count stays 0;
  - without the macro: the store is enqueued at 0x2000 with wstrb 1111.
- funct3=011 with XLEN=32 → st_illegal pulses for one cycle and nothing is enqueued. With XLEN=64, SD at 0x08 → wstrb 0xFF.
- mem_ready=0, five SW stores, DEPTH=4 → st_ready drops after the 4th; raise mem_ready → the entries drain in order and st_ready returns.
- Buffer half full, enqueue and dequeue in the same cycle → sb_count unchanged and the order is preserved across pointer wrap.
- rst_n pulsed low while 3 entries are queued → mem_valid=0, sb_count=0 and st_ready=1 immediately.
